// File: rtl/inst_loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
package inst_loader_pkg;

  typedef enum logic [2:0] {
    HDR0 = 3'd0,
    HDR1 = 3'd1,
    DATA = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } ld_state_t;

  localparam int LD_HDR_BYTES = 2;
  localparam int LD_WCNT_W    = 16;

endpackage

// File: rtl/inst_loader.sv
// Boot loader: header word count + little-endian 32-bit words from a byte
// stream, written to consecutive instruction-memory words while the core is held.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter  int INST_MEM_DEPTH  = 32,
  parameter  int INST_MEM_DAT_W  = 32,
  localparam int INST_MEM_ADDR_W = $clog2(INST_MEM_DEPTH) + 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_byte_vld,
  input  logic [7:0]                 s_byte_dat,
  output logic                       s_byte_rdy,
  input  logic                       ld_restart,
  output logic                       inst_wr_we,
  output logic [INST_MEM_ADDR_W-1:0] inst_wr_addr,
  output logic [INST_MEM_DAT_W-1:0]  inst_wr_dat,
  output logic                       cpu_hold,
  output logic                       ld_done,
  output logic                       ld_err
);

  ld_state_t                  state_q, state_d;
  logic [LD_WCNT_W-1:0]       wcnt_q, wcnt_d;
  logic [LD_WCNT_W-1:0]       widx_q, widx_d;
  logic [INST_MEM_DAT_W-1:0]  asm_q, asm_d;
  logic [1:0]                 bcnt_q, bcnt_d;
  logic                       err_q, err_d;
  logic                       we_q, we_d;
  logic [INST_MEM_ADDR_W-1:0] addr_q, addr_d;
  logic [INST_MEM_DAT_W-1:0]  dat_q, dat_d;

  logic                       hs_s;
  logic                       in_range_s;
  logic [31:0]                addr_full_s;
  logic [INST_MEM_DAT_W-1:0]  asm_shift_s;

  // Ready is a pure decode of the byte-accepting states.
  always_comb begin
    case (state_q)
      HDR0, HDR1, DATA: s_byte_rdy = 1'b1;
      default:          s_byte_rdy = 1'b0;
    endcase
  end

  assign hs_s        = s_byte_vld & s_byte_rdy;
  assign in_range_s  = ({16'd0, widx_q} < 32'(INST_MEM_DEPTH));
  assign addr_full_s = {14'd0, widx_q, 2'b00};
  assign asm_shift_s = {s_byte_dat, asm_q[INST_MEM_DAT_W-1:8]};

  // Next-state logic for the load FSM and its datapath.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    widx_d  = widx_q;
    asm_d   = asm_q;
    bcnt_d  = bcnt_q;
    err_d   = err_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    dat_d   = dat_q;
    case (state_q)
      HDR0: begin
        if (hs_s) begin
          wcnt_d[7:0] = s_byte_dat;
          state_d     = HDR1;
        end else begin
          state_d = HDR0;
        end
      end
      HDR1: begin
        if (hs_s) begin
          wcnt_d[15:8] = s_byte_dat;
          if ({s_byte_dat, wcnt_q[7:0]} == 16'd0) begin
            state_d = DONE;
          end else begin
            state_d = DATA;
          end
        end else begin
          state_d = HDR1;
        end
      end
      DATA: begin
        if (hs_s) begin
          asm_d  = asm_shift_s;
          bcnt_d = bcnt_q + 2'd1;
          // Write port is loaded on entry to WR; out-of-range words are dropped.
          if (bcnt_q == 2'd3) begin
            state_d = WR;
            we_d    = in_range_s;
            addr_d  = addr_full_s[INST_MEM_ADDR_W-1:0];
            dat_d   = asm_shift_s;
            if (!in_range_s) begin
              err_d = 1'b1;
            end else begin
              err_d = err_q;
            end
          end else begin
            state_d = DATA;
          end
        end else begin
          state_d = DATA;
        end
      end
      WR: begin
        widx_d = widx_q + 16'd1;
        if (widx_q == (wcnt_q - 16'd1)) begin
          state_d = DONE;
        end else begin
          state_d = DATA;
        end
      end
      DONE: begin
        if (ld_restart) begin
          state_d = HDR0;
          err_d   = 1'b0;
          widx_d  = 16'd0;
          bcnt_d  = 2'd0;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = HDR0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HDR0;
      wcnt_q  <= 16'd0;
      widx_q  <= 16'd0;
      asm_q   <= '0;
      bcnt_q  <= 2'd0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      widx_q  <= widx_d;
      asm_q   <= asm_d;
      bcnt_q  <= bcnt_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      dat_q   <= dat_d;
    end
  end

  assign inst_wr_we   = we_q;
  assign inst_wr_addr = addr_q;
  assign inst_wr_dat  = dat_q;
  assign ld_err       = err_q;
  assign ld_done      = (state_q == DONE);
  assign cpu_hold     = (state_q != DONE);

endmodule

// File: tb/tb_inst_loader.sv
// Directed self-checking bench for inst_loader.
module tb_inst_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_byte_vld;
  logic [7:0]  s_byte_dat;
  logic        s_byte_rdy;
  logic        ld_restart;
  logic        inst_wr_we;
  logic [6:0]  inst_wr_addr;
  logic [31:0] inst_wr_dat;
  logic        cpu_hold;
  logic        ld_done;
  logic        ld_err;

  int tests  = 0;
  int fails  = 0;
  int wr_cnt = 0;

  inst_loader dut (
    .clk          (clk),
    .rst          (rst),
    .s_byte_vld   (s_byte_vld),
    .s_byte_dat   (s_byte_dat),
    .s_byte_rdy   (s_byte_rdy),
    .ld_restart   (ld_restart),
    .inst_wr_we   (inst_wr_we),
    .inst_wr_addr (inst_wr_addr),
    .inst_wr_dat  (inst_wr_dat),
    .cpu_hold     (cpu_hold),
    .ld_done      (ld_done),
    .ld_err       (ld_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (inst_wr_we === 1'b1) wr_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Presents one byte (after an optional idle gap) and returns 1 ns after the handshake edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit accepted = 1'b0;
    int n = 0;
    s_byte_vld = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    s_byte_vld = 1'b1;
    s_byte_dat = b;
    while (!accepted && n < 50) begin
      accepted = (s_byte_rdy === 1'b1);
      @(posedge clk); #1;
      n++;
    end
    s_byte_vld = 1'b0;
    if (!accepted) begin
      tests++; fails++;
      $display("FAIL byte_timeout byte %h: rdy stayed %b, required 1", b, s_byte_rdy);
    end
  endtask

  // Sends one word little-endian and checks the WR cycle that follows it.
  task automatic send_word(input logic [31:0] w, input bit gaps, input bit exp_we,
                           input logic [6:0] exp_addr, input bit exp_err, input int idx);
    logic [31:0] tmp = w;
    for (int i = 0; i < 4; i++) begin
      send_byte(tmp[8*i +: 8], gaps ? int'($urandom_range(0, 3)) : 0);
    end
    tests++;
    if (inst_wr_we !== exp_we) begin
      fails++; $display("FAIL wr_we word%0d: got %b, required %b", idx, inst_wr_we, exp_we);
    end
    if (exp_we) begin
      tests++;
      if (inst_wr_addr !== exp_addr) begin
        fails++; $display("FAIL wr_addr word%0d: got %h, required %h", idx, inst_wr_addr, exp_addr);
      end
      tests++;
      if (inst_wr_dat !== w) begin
        fails++; $display("FAIL wr_dat word%0d: got %h, required %h", idx, inst_wr_dat, w);
      end
    end
    tests++;
    if (s_byte_rdy !== 1'b0) begin
      fails++; $display("FAIL wr_rdy word%0d: got %b, required 0", idx, s_byte_rdy);
    end
    tests++;
    if (cpu_hold !== 1'b1 || ld_done !== 1'b0) begin
      fails++; $display("FAIL wr_hold word%0d: hold %b done %b, required 1 0", idx, cpu_hold, ld_done);
    end
    tests++;
    if (ld_err !== exp_err) begin
      fails++; $display("FAIL wr_err word%0d: got %b, required %b", idx, ld_err, exp_err);
    end
  endtask

  // Checks the DONE state now and for 3 cycles with a byte held on the link.
  task automatic check_done(input bit exp_err, input int wr_base, input int exp_writes, input int tag);
    s_byte_vld = 1'b1;
    s_byte_dat = 8'hFF;
    for (int c = 0; c < 4; c++) begin
      tests++;
      if (ld_done !== 1'b1 || cpu_hold !== 1'b0 || s_byte_rdy !== 1'b0 || inst_wr_we !== 1'b0) begin
        fails++;
        $display("FAIL done%0d cyc%0d: done %b hold %b rdy %b we %b, required 1 0 0 0",
                 tag, c, ld_done, cpu_hold, s_byte_rdy, inst_wr_we);
      end
      @(posedge clk); #1;
    end
    s_byte_vld = 1'b0;
    tests++;
    if (ld_err !== exp_err) begin
      fails++; $display("FAIL done_err%0d: got %b, required %b", tag, ld_err, exp_err);
    end
    tests++;
    if (wr_cnt - wr_base != exp_writes) begin
      fails++; $display("FAIL write_count%0d: got %0d, required %0d", tag, wr_cnt - wr_base, exp_writes);
    end
  endtask

  task automatic test_reset(input int tag);
    rst = 1'b1;
    #2;
    tests++;
    if (s_byte_rdy !== 1'b1 || inst_wr_we !== 1'b0 || inst_wr_addr !== 7'h00 || inst_wr_dat !== 32'h0) begin
      fails++;
      $display("FAIL reset%0d_wr: rdy %b we %b addr %h dat %h, required 1 0 00 00000000",
               tag, s_byte_rdy, inst_wr_we, inst_wr_addr, inst_wr_dat);
    end
    tests++;
    if (cpu_hold !== 1'b1 || ld_done !== 1'b0 || ld_err !== 1'b0) begin
      fails++;
      $display("FAIL reset%0d_status: hold %b done %b err %b, required 1 0 0", tag, cpu_hold, ld_done, ld_err);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_restart(input int tag);
    ld_restart = 1'b1;
    @(posedge clk); #1;
    ld_restart = 1'b0;
    tests++;
    if (cpu_hold !== 1'b1 || ld_done !== 1'b0 || ld_err !== 1'b0 || s_byte_rdy !== 1'b1) begin
      fails++;
      $display("FAIL restart%0d: hold %b done %b err %b rdy %b, required 1 0 0 1",
               tag, cpu_hold, ld_done, ld_err, s_byte_rdy);
    end
  endtask

  task automatic test_basic(input bit gaps, input int tag);
    int base = wr_cnt;
    send_byte(8'h02, 0);
    send_byte(8'h00, gaps ? 2 : 0);
    send_word(32'h0000_0013, gaps, 1'b1, 7'h00, 1'b0, 0);
    send_word(32'h0010_0093, gaps, 1'b1, 7'h04, 1'b0, 1);
    @(posedge clk); #1;
    check_done(1'b0, base, 2, tag);
  endtask

  task automatic test_zero();
    int base = wr_cnt;
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    check_done(1'b0, base, 0, 2);
  endtask

  task automatic test_overflow();
    int base = wr_cnt;
    send_byte(8'h21, 0);
    send_byte(8'h00, 0);
    for (int k = 0; k < 33; k++) begin
      send_word(32'hA500_0000 + k, 1'b0, (k < 32), 7'(k * 4), (k == 32), 100 + k);
    end
    @(posedge clk); #1;
    check_done(1'b1, base, 32, 3);
  endtask

  task automatic test_restart();
    int base;
    do_restart(4);
    base = wr_cnt;
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_word(32'hDEAD_BEEF, 1'b0, 1'b1, 7'h00, 1'b0, 200);
    @(posedge clk); #1;
    check_done(1'b0, base, 1, 4);
  endtask

  task automatic test_rst_mid();
    int base;
    do_restart(5);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    base = wr_cnt;
    test_reset(5);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_word(32'h1234_5678, 1'b0, 1'b1, 7'h00, 1'b0, 300);
    @(posedge clk); #1;
    check_done(1'b0, base, 1, 5);
  endtask

  initial begin
    rst        = 1'b1;
    s_byte_vld = 1'b0;
    s_byte_dat = 8'h00;
    ld_restart = 1'b0;
    #3;
    test_reset(0);
    test_basic(1'b0, 0);
    do_restart(1);
    test_zero();
    do_restart(2);
    test_basic(1'b1, 1);
    do_restart(3);
    test_overflow();
    test_restart();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
